// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, line and
// timing constants, and sanitising helpers for the runtime frame format.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned MIN_BIT_PERIOD    = 10;
  localparam int unsigned DEFAULT_DATA_SIZE = 8;
  localparam int unsigned MIN_DATA_SIZE     = 5;
  localparam logic        IDLE_LEVEL        = 1'b1;

  // Out-of-range data sizes fall back to a full byte.
  function automatic logic [3:0] legal_data_size(input logic [3:0] ds);
    return ((ds < 4'(MIN_DATA_SIZE)) || (ds > 4'(DEFAULT_DATA_SIZE))) ?
           4'(DEFAULT_DATA_SIZE) : ds;
  endfunction

  function automatic logic [13:0] legal_bit_period(input logic [13:0] bp);
    return (bp < 14'(MIN_BIT_PERIOD)) ? 14'(MIN_BIT_PERIOD) : bp;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit timing for one serial frame: a cycle counter paced by bit_period and
// a bit counter indexing start (0), data bits (1..N) and stop (last_bit).
module tx_bit_timer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        en,
  input  logic [13:0] bit_period,
  input  logic [3:0]  last_bit,
  output logic        bit_done,
  output logic        frame_done,
  output logic [3:0]  bit_cnt
);

  logic [13:0] cyc_q, cyc_d;
  logic [3:0]  bit_q, bit_d;

  always_comb begin
    bit_done   = en && (cyc_q == (bit_period - 14'd1));
    frame_done = bit_done && (bit_q == last_bit);
    cyc_d      = cyc_q + 14'd1;
    bit_d      = bit_q;
    // Counters park at zero whenever no frame bit is on the line.
    if (!en) begin
      cyc_d = '0;
      bit_d = '0;
    end else if (bit_done) begin
      cyc_d = '0;
      bit_d = frame_done ? 4'd0 : (bit_q + 4'd1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cyc_q <= '0;
      bit_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      bit_q <= bit_d;
    end
  end

  assign bit_cnt = bit_q;

endmodule

// File: rtl/tx_block.sv
// UART transmitter: one-byte holding buffer, IDLE/LOAD/START/DATA/STOP FSM
// and LSB-first shift register; serial_out comes straight from a flop.
module tx_block
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  input  logic [7:0]  tx_data,
  input  logic        load_data,
  output logic        serial_out,
  output logic        tx_busy,
  output logic        buffer_full,
  output logic        overrun_error,
  output state_t      fsm_state
);

  state_t      state_q, state_d;
  logic [7:0]  buf_q, buf_d;
  logic        full_q, full_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  ds_q, ds_d;
  logic [13:0] period_q, period_d;
  logic        serial_q, serial_d;
  logic        accept;
  logic        bit_done, frame_done;
  logic [3:0]  bit_cnt;

  // Handshake: load_data is a one-cycle strobe with no ready; buffer_full is
  // the back-pressure flag. The LOAD cycle frees the buffer on its closing
  // edge, so a strobe in LOAD is accepted; any other strobe while full is
  // dropped and flagged in overrun_error.
  assign accept = load_data && (!full_q || (state_q == LOAD));

  always_comb begin
    buf_d  = buf_q;
    full_d = full_q;
    ovr_d  = ovr_q;
    if (state_q == LOAD) full_d = 1'b0;
    if (accept) begin
      buf_d  = tx_data;
      full_d = 1'b1;
      ovr_d  = 1'b0;
    end else if (load_data) begin
      ovr_d  = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    ds_d     = ds_q;
    period_d = period_q;
    case (state_q)
      IDLE:  if (full_q) state_d = LOAD;
      LOAD: begin
        shift_d  = buf_q;
        ds_d     = legal_data_size(data_size);
        period_d = legal_bit_period(bit_period);
        state_d  = START;
      end
      START: if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == ds_q) state_d = STOP;
          else                 shift_d = shift_q >> 1;
        end
      end
      STOP:  if (frame_done) state_d = full_q ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    // Line level is computed from the next state so the flop leads no logic.
    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
      default: serial_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      full_q   <= 1'b0;
      ovr_q    <= 1'b0;
      shift_q  <= '0;
      ds_q     <= 4'(DEFAULT_DATA_SIZE);
      period_q <= 14'(MIN_BIT_PERIOD);
      serial_q <= IDLE_LEVEL;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      full_q   <= full_d;
      ovr_q    <= ovr_d;
      shift_q  <= shift_d;
      ds_q     <= ds_d;
      period_q <= period_d;
      serial_q <= serial_d;
    end
  end

  tx_bit_timer u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         ((state_q == START) || (state_q == DATA) || (state_q == STOP)),
    .bit_period (period_q),
    .last_bit   (ds_q + 4'd1),
    .bit_done   (bit_done),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt)
  );

  assign serial_out    = serial_q;
  assign tx_busy       = (state_q != IDLE);
  assign buffer_full   = full_q;
  assign overrun_error = ovr_q;
  assign fsm_state     = state_q;

endmodule

// File: tb/tb_tx_block.sv
// Bench for tx_block: a table of frame formats plus hand-written sequences;
// a line monitor checks every cycle of each frame against an expected queue.
module tb_tx_block;
  import uart_pkg::*;

  logic        clk;
  logic        n_rst;
  logic [3:0]  data_size;
  logic [13:0] bit_period;
  logic [7:0]  tx_data;
  logic        load_data;
  logic        serial_out;
  logic        tx_busy;
  logic        buffer_full;
  logic        overrun_error;
  state_t      fsm_state;

  int checks = 0;
  int errors = 0;
  int frames_exp = 0;
  int frames_seen = 0;

  // Each entry: {bit_period, data_size, data} as in effect at LOAD time.
  logic [25:0] exp_q[$];

  typedef struct {
    logic [3:0]  ds;
    logic [13:0] bp;
    logic [7:0]  data;
    logic [3:0]  exp_ds;
    logic [13:0] exp_bp;
  } vec_t;
  vec_t vecs[10];

  tx_block dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .data_size     (data_size),
    .bit_period    (bit_period),
    .tx_data       (tx_data),
    .load_data     (load_data),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy),
    .buffer_full   (buffer_full),
    .overrun_error (overrun_error),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Call at a negedge; the strobe is sampled on the following posedge.
  task automatic write_byte(input logic [7:0] d, input logic acc,
                            input logic [3:0] eds, input logic [13:0] ebp);
    tx_data   = d;
    load_data = 1'b1;
    if (acc) begin
      exp_q.push_back({ebp, eds, d});
      frames_exp++;
    end
    @(negedge clk);
    load_data = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((tx_busy || buffer_full) && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("idle_reached", 32'(tx_busy | buffer_full), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_low();
    int c = 0;
    while (serial_out !== 1'b0 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("start_bit_seen", 32'(serial_out), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Entered at the negedge where the start bit is first seen (cycle 0).
  task automatic run_frame(output logic b2b, output logic aborted);
    logic [25:0] e;
    logic [7:0]  d;
    logic        lvl;
    int          n, p, b, bad_at;
    b2b     = 1'b0;
    aborted = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: start bit with empty expected queue (t=%0t)", $time);
      aborted = 1'b1;
      return;
    end
    e      = exp_q.pop_front();
    p      = int'(e[25:12]);
    n      = int'(e[11:8]) + 2;
    d      = e[7:0];
    bad_at = -1;
    for (int i = 0; i < n * p; i++) begin
      if (i > 0) @(negedge clk);
      if (!n_rst) begin
        aborted = 1'b1;
        return;
      end
      b   = i / p;
      lvl = (b == 0) ? 1'b0 : ((b == n - 1) ? 1'b1 : d[b-1]);
      if ((serial_out !== lvl || tx_busy !== 1'b1) && bad_at < 0) bad_at = i;
    end
    check("frame_first_bad_cycle", 32'(bad_at), 32'hffff_ffff);
    @(negedge clk);
    if (!n_rst) begin
      aborted = 1'b1;
      return;
    end
    b2b = (exp_q.size() > 0);
    check("line_high_after_stop", 32'(serial_out), 32'd1);
    check("busy_after_stop", 32'(tx_busy), 32'(b2b));
    frames_seen++;
  endtask

  initial begin : monitor
    logic prev, b2b, ab;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (n_rst && prev && !serial_out) begin
        run_frame(b2b, ab);
        while (b2b && !ab) begin
          @(negedge clk);
          check("b2b_start_after_one_load_cycle", 32'(serial_out), 32'd0);
          if (serial_out !== 1'b0) break;
          run_frame(b2b, ab);
        end
      end
      prev = n_rst ? serial_out : 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    n_rst      = 1'b0;
    load_data  = 1'b0;
    tx_data    = '0;
    data_size  = 4'd8;
    bit_period = 14'd10;

    vecs[0] = '{4'd8,  14'd10, 8'hA5, 4'd8, 14'd10};
    vecs[1] = '{4'd5,  14'd20, 8'hFF, 4'd5, 14'd20};
    vecs[2] = '{4'd12, 14'd3,  8'h3C, 4'd8, 14'd10};
    vecs[3] = '{4'd0,  14'd9,  8'hC3, 4'd8, 14'd10};
    vecs[4] = '{4'd6,  14'd11, 8'h2A, 4'd6, 14'd11};
    vecs[5] = '{4'd15, 14'd10, 8'h81, 4'd8, 14'd10};
    vecs[6] = '{4'd4,  14'd12, 8'h5E, 4'd8, 14'd12};
    for (int i = 7; i < 10; i++) begin
      vecs[i].ds     = 4'($urandom_range(5, 8));
      vecs[i].bp     = 14'($urandom_range(10, 16));
      vecs[i].data   = 8'($urandom_range(0, 255));
      vecs[i].exp_ds = vecs[i].ds;
      vecs[i].exp_bp = vecs[i].bp;
    end

    // Reset state, including a strobe that must be ignored in reset.
    repeat (3) @(negedge clk);
    load_data = 1'b1;
    @(negedge clk);
    load_data = 1'b0;
    check("rst_serial", 32'(serial_out), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_full", 32'(buffer_full), 32'd0);
    check("rst_overrun", 32'(overrun_error), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    n_rst = 1'b1;
    repeat (3) @(negedge clk);

    // Write-to-line latency from idle.
    write_byte(8'h96, 1'b1, 4'd8, 14'd10);
    check("lat_k_full", 32'(buffer_full), 32'd1);
    check("lat_k_busy", 32'(tx_busy), 32'd0);
    check("lat_k_serial", 32'(serial_out), 32'd1);
    @(negedge clk);
    check("lat_k1_state", 32'(fsm_state), 32'(LOAD));
    check("lat_k1_busy", 32'(tx_busy), 32'd1);
    check("lat_k1_serial", 32'(serial_out), 32'd1);
    @(negedge clk);
    check("lat_k2_serial", 32'(serial_out), 32'd0);
    check("lat_k2_full", 32'(buffer_full), 32'd0);
    check("lat_k2_state", 32'(fsm_state), 32'(START));
    wait_idle();

    // Table of formats, including clamped sizes and periods.
    for (int i = 0; i < 10; i++) begin
      data_size  = vecs[i].ds;
      bit_period = vecs[i].bp;
      write_byte(vecs[i].data, 1'b1, vecs[i].exp_ds, vecs[i].exp_bp);
      check("vec_buffer_full", 32'(buffer_full), 32'd1);
      wait_idle();
    end

    // Back-to-back frames, overrun drop and sticky overrun flag.
    data_size  = 4'd8;
    bit_period = 14'd10;
    write_byte(8'h01, 1'b1, 4'd8, 14'd10);
    repeat (5) @(negedge clk);
    check("ovr_in_start", 32'(fsm_state), 32'(START));
    write_byte(8'h02, 1'b1, 4'd8, 14'd10);
    check("ovr_full_after_02", 32'(buffer_full), 32'd1);
    check("ovr_clear_after_02", 32'(overrun_error), 32'd0);
    write_byte(8'h03, 1'b0, 4'd8, 14'd10);
    check("ovr_set_after_03", 32'(overrun_error), 32'd1);
    check("ovr_full_after_03", 32'(buffer_full), 32'd1);
    begin
      int c = 0;
      while (buffer_full && c < 500) begin
        @(negedge clk);
        c++;
      end
    end
    check("ovr_buffer_drained", 32'(buffer_full), 32'd0);
    check("ovr_sticky", 32'(overrun_error), 32'd1);
    repeat (3) @(negedge clk);
    write_byte(8'h04, 1'b1, 4'd8, 14'd10);
    check("ovr_cleared_by_write", 32'(overrun_error), 32'd0);
    wait_idle();

    // A strobe during the LOAD cycle refills the buffer without overrun.
    write_byte(8'h11, 1'b1, 4'd8, 14'd10);
    @(negedge clk);
    check("loadwr_in_load", 32'(fsm_state), 32'(LOAD));
    write_byte(8'h22, 1'b1, 4'd8, 14'd10);
    check("loadwr_full", 32'(buffer_full), 32'd1);
    check("loadwr_no_overrun", 32'(overrun_error), 32'd0);
    wait_idle();

    // Reset in the third data bit with a byte waiting in the buffer.
    write_byte(8'h5A, 1'b1, 4'd8, 14'd10);
    wait_low();
    write_byte(8'h77, 1'b1, 4'd8, 14'd10);
    repeat (31) @(negedge clk);
    check("rst_mid_in_data", 32'(fsm_state), 32'(DATA));
    #2 n_rst = 1'b0;
    #1;
    check("rst_mid_serial", 32'(serial_out), 32'd1);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    check("rst_mid_full", 32'(buffer_full), 32'd0);
    check("rst_mid_state", 32'(fsm_state), 32'(IDLE));
    exp_q.delete();
    frames_exp -= 2;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    write_byte(8'h4B, 1'b1, 4'd8, 14'd10);
    wait_idle();

    // Format changes mid-frame affect only the next frame.
    data_size  = 4'd8;
    bit_period = 14'd10;
    write_byte(8'hC6, 1'b1, 4'd8, 14'd10);
    wait_low();
    repeat (15) @(negedge clk);
    bit_period = 14'd40;
    data_size  = 4'd5;
    write_byte(8'h39, 1'b1, 4'd5, 14'd40);
    wait_idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("frames_seen", 32'(frames_seen), 32'(frames_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
